dcache_ctrl: RTL and testbench
==============================

# dcache_ctrl

Direct-mapped, write-through, no-write-allocate data-cache controller for the MEM stage of the 5-stage MIPS pipeline. It serves `MEM_memRead`/`MEM_memWrite` accesses from the EX_MEM register, fills lines from main memory over a ready handshake, and drives `dmemError`. The pipeline register controller turns `dmemError` into a full-pipeline freeze (stall_2) for as long as the miss or write is in progress.

## Interface
- `INDEX_BITS`, 4: line index width. The cache holds 2^INDEX_BITS lines.
- `LINE_WORDS`, 4 (fixed): 32-bit words per line. Word offset is `addr[3:2]`.
- `Clk` in 1: single clock, all state updates on posedge. Reset is asynchronous and active-high.
- `Rst` in 1: asynchronous active-high reset.
- `MEM_memRead` in 1: load in the MEM stage.
- `MEM_memWrite` in 1: store in the MEM stage. Takes priority if both are high.
- `MEM_addr` in 32: byte address, word aligned. Bits [1:0] are ignored.
- `MEM_wData` in 32: store data.
- `dmemRData` out 32: load data, combinational from the data array.
- `dmemError` out 1: stall request to the pipeline register controller.
- `memReq` out 1: main-memory request, held until `memReady`.
- `memWe` out 1: 1 = memory write, 0 = memory read.
- `memAddr` out 32: main-memory word address (byte form, [1:0]=00).
- `memWData` out 32: main-memory write data.
- `memRData` in 32: main-memory read data, valid when `memReady`=1.
- `memReady` in 1: completes the current memory transfer in that cycle.

## Operation
- Address split:
  - tag = `addr[31:4+INDEX_BITS]`
  - index = `addr[3+INDEX_BITS:4]`
  - offset = `addr[3:2]`
- hit = `valid[index]` && (`tagArr[index]` == tag).
- States: IDLE, REFILL, WRITE, RESUME.
- **IDLE:**
  - Read hit: `dmemRData` = word[index][offset], `dmemError`=0, stay in IDLE.
  - Read miss: `dmemError`=1 combinationally. Next state is REFILL; clear `valid[index]`, latch tag/index, set `cnt`=0.
  - Write (hit or miss): `dmemError`=1. Latch address and data. Next state is WRITE. On a hit, the cache word is updated at this edge; a miss does not allocate.
  - No access: `dmemError`=0.
- **REFILL:**
  - Drive `memReq`=1, `memWe`=0, `memAddr`={latched tag, index, `cnt`, 2'b00}. `dmemError`=1.
  - Each cycle with `memReady`=1: write `memRData` into word[`cnt`], then `cnt`++.
  - On `memReady` with `cnt`=3: set `valid`, write `tagArr`, `cnt` wraps to 0, go to IDLE. The held load then hits on the next cycle.
- **WRITE:**
  - Drive `memReq`=1, `memWe`=1, `memAddr`/`memWData` from the latched values. `dmemError`=1.
  - On `memReady`, go to RESUME.
- **RESUME:**
  - One cycle, `dmemError`=0, `memReq`=0, so the pipeline advances past the store.
  - No new access is accepted in this cycle: the still-present `MEM_memWrite` for the same store is ignored.
  - Go to IDLE.
- `memReq` is 0 in IDLE and RESUME. Address and data must stay stable while `memReq`=1 and `memReady`=0.
- Reset (asynchronous, any state, including mid-REFILL or mid-WRITE):
  - state=IDLE, all `valid`=0, `cnt`=0, latches=0.
  - Outputs: `memReq`=0, `memWe`=0, `memAddr`=0, `memWData`=0.
  - A partially refilled line stays invalid.
- Data and tag arrays are not reset.

## Timing
- Read hit: 0 stall cycles; data is combinational the same cycle.
- Read miss, memory latency L cycles per word (L≥1): `dmemError` high for 1 + 4L cycles (IDLE cycle plus REFILL), then the hit cycle with `dmemError`=0.
- Write, latency L: `dmemError` high for 1 + L cycles, then RESUME with `dmemError`=0.
- `dmemError` is glitch-free before the negedge sample point of the pipe controller: it is decoded from the posedge state and the EX_MEM register outputs only.
- `memReady` is ignored outside REFILL and WRITE.
- A new access in the cycle after RESUME is treated normally.

## Test plan
- Reset, then read 0x0000_0040 with memory returning 0xA0..0xA3 for words 0x40..0x4C, `memReady` every cycle:
  - `dmemError`=1 for 5 cycles, memAddr sequence 0x40, 0x44, 0x48, 0x4C.
  - Then `dmemRData`=0xA0 with `dmemError`=0.
  - Re-read 0x48 gives 0xA2 with 0 stalls.
- Store 0xDEAD_BEEF to 0x44 (hit) with `memReady` delayed 3 cycles:
  - `dmemError`=1 for 4 cycles, `memWe`=1, memWData=0xDEADBEEF.
  - RESUME with exactly one write issued.
  - A later read of 0x44 returns 0xDEADBEEF without a miss.
- Store to 0x0000_1000 (miss):
  - One memory write, no refill.
  - Read of 0x1000 then misses and refills.
- Conflict: read 0x040, then 0x140 (same index 4 with INDEX_BITS=4, different tag):
  - Second read misses.
  - Re-read of 0x040 misses again.
- Assert `Rst` during the 3rd refill beat:
  - `memReq`=0 immediately.
  - A subsequent read of the same address misses and performs a full 4-beat refill.
- `MEM_memRead`=`MEM_memWrite`=1: treated as a write, memWe=1, no refill.

Source files
------------

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller for the
// MEM stage. Loads that miss refill a whole 4-word line from main memory; stores
// are always written through and only update the cache on a hit. dmemError
// stalls the whole pipeline while a refill or write is outstanding.
module dcache_ctrl #(
    parameter int unsigned INDEX_BITS = 4
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        MEM_memRead,
    input  logic        MEM_memWrite,
    input  logic [31:0] MEM_addr,
    input  logic [31:0] MEM_wData,
    output logic [31:0] dmemRData,
    output logic        dmemError,
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [31:0] memWData,
    input  logic [31:0] memRData,
    input  logic        memReady
);

    localparam int unsigned NumLines = 1 << INDEX_BITS;
    localparam int unsigned TagBits  = 28 - INDEX_BITS;

    typedef enum logic [1:0] {
        StIdle,
        StRefill,
        StWrite,
        StResume
    } state_e;

    state_e state_q, state_d;

    logic [NumLines-1:0] valid_q, valid_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [31:2]         addr_q, addr_d;   // word address of the pending miss/store
    logic [31:0]         wdata_q, wdata_d;

    logic [31:0]        data_arr [NumLines*4];
    logic [TagBits-1:0] tag_arr  [NumLines];

    logic [TagBits-1:0]    req_tag;
    logic [INDEX_BITS-1:0] req_idx;
    logic [1:0]            req_off;
    logic [TagBits-1:0]    lat_tag;
    logic [INDEX_BITS-1:0] lat_idx;
    logic                  hit;
    logic                  hit_we;
    logic                  refill_we;
    logic                  tag_we;
    logic                  unused_byte_offset;

    assign req_tag = MEM_addr[31:4+INDEX_BITS];
    assign req_idx = MEM_addr[3+INDEX_BITS:4];
    assign req_off = MEM_addr[3:2];
    assign lat_tag = addr_q[31:4+INDEX_BITS];
    assign lat_idx = addr_q[3+INDEX_BITS:4];

    // Accesses are word aligned; the byte offset carries no information.
    assign unused_byte_offset = ^MEM_addr[1:0];

    assign hit       = valid_q[req_idx] && (tag_arr[req_idx] == req_tag);
    assign dmemRData = data_arr[{req_idx, req_off}];

    // Next-state and output decode; depends only on registered state and the
    // EX_MEM inputs so dmemError settles well before the negedge sample.
    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        dmemError = 1'b0;
        memReq    = 1'b0;
        memWe     = 1'b0;
        memAddr   = 32'h0;
        memWData  = 32'h0;
        hit_we    = 1'b0;
        refill_we = 1'b0;
        tag_we    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (MEM_memWrite) begin
                    dmemError = 1'b1;
                    addr_d    = MEM_addr[31:2];
                    wdata_d   = MEM_wData;
                    hit_we    = hit;
                    state_d   = StWrite;
                end else if (MEM_memRead && !hit) begin
                    dmemError        = 1'b1;
                    valid_d[req_idx] = 1'b0;
                    addr_d           = MEM_addr[31:2];
                    cnt_d            = 2'd0;
                    state_d          = StRefill;
                end
            end
            StRefill: begin
                dmemError = 1'b1;
                memReq    = 1'b1;
                memAddr   = {addr_q[31:4], cnt_q, 2'b00};
                if (memReady) begin
                    refill_we = 1'b1;
                    cnt_d     = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        valid_d[lat_idx] = 1'b1;
                        tag_we           = 1'b1;
                        state_d          = StIdle;
                    end
                end
            end
            StWrite: begin
                dmemError = 1'b1;
                memReq    = 1'b1;
                memWe     = 1'b1;
                memAddr   = {addr_q, 2'b00};
                memWData  = wdata_q;
                if (memReady) begin
                    state_d = StResume;
                end
            end
            StResume: begin
                // Let the pipeline step past the store; its MEM_memWrite is ignored.
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Control state with asynchronous reset; a partial refill is left invalid.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= StIdle;
            valid_q <= '0;
            cnt_q   <= 2'd0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Data and tag arrays; not reset, validity is tracked by valid_q alone.
    always_ff @(posedge Clk) begin
        if (hit_we) begin
            data_arr[{req_idx, req_off}] <= MEM_wData;
        end
        if (refill_we) begin
            data_arr[{lat_idx, cnt_q}] <= memRData;
        end
        if (tag_we) begin
            tag_arr[lat_idx] <= lat_tag;
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed self-checking bench for dcache_ctrl: read miss/refill, read hit,
// write hit and miss, tag conflict, reset during refill, read+write priority.
module tb_dcache_ctrl;

    logic        Clk;
    logic        Rst;
    logic        MEM_memRead;
    logic        MEM_memWrite;
    logic [31:0] MEM_addr;
    logic [31:0] MEM_wData;
    logic [31:0] dmemRData;
    logic        dmemError;
    logic        memReq;
    logic        memWe;
    logic [31:0] memAddr;
    logic [31:0] memWData;
    logic [31:0] memRData;
    logic        memReady;

    dcache_ctrl #(
        .INDEX_BITS(4)
    ) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .MEM_memRead (MEM_memRead),
        .MEM_memWrite(MEM_memWrite),
        .MEM_addr    (MEM_addr),
        .MEM_wData   (MEM_wData),
        .dmemRData   (dmemRData),
        .dmemError   (dmemError),
        .memReq      (memReq),
        .memWe       (memWe),
        .memAddr     (memAddr),
        .memWData    (memWData),
        .memRData    (memRData),
        .memReady    (memReady)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Main-memory model: fixed latency per transfer, write-through updates it.
    logic [31:0] mem_words [0:2047];
    int          lat        = 1;
    int          wait_cnt   = 0;
    int          read_beats = 0;
    int          write_cnt  = 0;
    logic [31:0] last_waddr = 32'h0;
    logic [31:0] last_wdata = 32'h0;
    logic        last_we    = 1'b0;
    logic [31:0] addr_log [$];

    always @(negedge Clk) begin
        memRData = mem_words[memAddr[12:2]];
        if (memReq) begin
            if (wait_cnt >= lat - 1) begin
                memReady = 1'b1;
                wait_cnt = 0;
                last_we  = memWe;
                if (memWe) begin
                    write_cnt++;
                    last_waddr = memAddr;
                    last_wdata = memWData;
                    mem_words[memAddr[12:2]] = memWData;
                end else begin
                    read_beats++;
                    addr_log.push_back(memAddr);
                end
            end else begin
                memReady = 1'b0;
                wait_cnt++;
            end
        end else begin
            memReady = 1'b0;
            wait_cnt = 0;
        end
    end

    // Present one access and count the cycles dmemError holds it; returns in
    // the first cycle with dmemError low (hit cycle or RESUME).
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wd, output int stalls);
        @(posedge Clk);
        #1;
        MEM_memRead  = rd;
        MEM_memWrite = wr;
        MEM_addr     = addr;
        MEM_wData    = wd;
        #1;
        stalls = 0;
        while (dmemError && stalls < 200) begin
            @(posedge Clk);
            #2;
            stalls++;
        end
    endtask

    task automatic idle_cycle();
        @(posedge Clk);
        #1;
        MEM_memRead  = 1'b0;
        MEM_memWrite = 1'b0;
        #1;
    endtask

    int stalls;
    int b0;
    int w0;

    initial begin
        for (int i = 0; i < 2048; i++) mem_words[i] = 32'h1000_0000 + i;
        mem_words[16] = 32'hA0;
        mem_words[17] = 32'hA1;
        mem_words[18] = 32'hA2;
        mem_words[19] = 32'hA3;
        memReady     = 1'b0;
        memRData     = 32'h0;
        MEM_memRead  = 1'b0;
        MEM_memWrite = 1'b0;
        MEM_addr     = 32'h0;
        MEM_wData    = 32'h0;
        Rst          = 1'b0;
        #1 Rst = 1'b1;
        #12;
        check_eq("rst_memReq", {31'h0, memReq}, 32'h0);
        check_eq("rst_memWe", {31'h0, memWe}, 32'h0);
        check_eq("rst_memAddr", memAddr, 32'h0);
        check_eq("rst_memWData", memWData, 32'h0);
        check_eq("rst_dmemError", {31'h0, dmemError}, 32'h0);
        #9 Rst = 1'b0;

        // Read miss with single-cycle memory.
        lat = 1;
        b0  = read_beats;
        addr_log.delete();
        do_access(1'b1, 1'b0, 32'h40, 32'h0, stalls);
        check_eq("miss40_stalls", stalls, 32'd5);
        check_eq("miss40_data", dmemRData, 32'hA0);
        check_eq("miss40_beats", read_beats - b0, 32'd4);
        check_eq("miss40_log_size", addr_log.size(), 32'd4);
        for (int i = 0; i < 4 && i < addr_log.size(); i++)
            check_eq("miss40_addr_seq", addr_log[i], 32'h40 + 32'(i * 4));

        do_access(1'b1, 1'b0, 32'h48, 32'h0, stalls);
        check_eq("hit48_stalls", stalls, 32'd0);
        check_eq("hit48_data", dmemRData, 32'hA2);

        // Write hit with 3-cycle memory.
        lat = 3;
        w0  = write_cnt;
        b0  = read_beats;
        do_access(1'b0, 1'b1, 32'h44, 32'hDEAD_BEEF, stalls);
        check_eq("wr44_stalls", stalls, 32'd4);
        check_eq("wr44_resume_req", {31'h0, memReq}, 32'h0);
        check_eq("wr44_writes", write_cnt - w0, 32'd1);
        check_eq("wr44_we", {31'h0, last_we}, 32'h1);
        check_eq("wr44_addr", last_waddr, 32'h44);
        check_eq("wr44_data", last_wdata, 32'hDEAD_BEEF);
        idle_cycle();
        check_eq("wr44_after_err", {31'h0, dmemError}, 32'h0);
        check_eq("wr44_after_req", {31'h0, memReq}, 32'h0);
        check_eq("wr44_single_write", write_cnt - w0, 32'd1);
        check_eq("wr44_no_refill", read_beats - b0, 32'd0);

        lat = 1;
        do_access(1'b1, 1'b0, 32'h44, 32'h0, stalls);
        check_eq("rd44_stalls", stalls, 32'd0);
        check_eq("rd44_data", dmemRData, 32'hDEAD_BEEF);

        // Write miss: no allocation.
        w0 = write_cnt;
        b0 = read_beats;
        do_access(1'b0, 1'b1, 32'h1000, 32'h1234_5678, stalls);
        check_eq("wr1000_stalls", stalls, 32'd2);
        check_eq("wr1000_writes", write_cnt - w0, 32'd1);
        check_eq("wr1000_no_refill", read_beats - b0, 32'd0);
        check_eq("wr1000_addr", last_waddr, 32'h1000);
        do_access(1'b1, 1'b0, 32'h1000, 32'h0, stalls);
        check_eq("rd1000_stalls", stalls, 32'd5);
        check_eq("rd1000_data", dmemRData, 32'h1234_5678);

        // Tag conflict on index 4.
        do_access(1'b1, 1'b0, 32'h140, 32'h0, stalls);
        check_eq("rd140_stalls", stalls, 32'd5);
        check_eq("rd140_data", dmemRData, 32'h1000_0050);
        do_access(1'b1, 1'b0, 32'h40, 32'h0, stalls);
        check_eq("rd40_again_stalls", stalls, 32'd5);
        check_eq("rd40_again_data", dmemRData, 32'hA0);

        // Reset during the third refill beat.
        b0 = read_beats;
        @(posedge Clk);
        #1;
        MEM_memRead = 1'b1;
        MEM_addr    = 32'h80;
        @(posedge Clk);
        @(posedge Clk);
        @(posedge Clk);
        #2;
        check_eq("rst_mid_req_before", {31'h0, memReq}, 32'h1);
        check_eq("rst_mid_addr_before", memAddr, 32'h88);
        Rst         = 1'b1;
        MEM_memRead = 1'b0;
        #1;
        check_eq("rst_mid_req", {31'h0, memReq}, 32'h0);
        check_eq("rst_mid_addr", memAddr, 32'h0);
        check_eq("rst_mid_err", {31'h0, dmemError}, 32'h0);
        @(posedge Clk);
        #1 Rst = 1'b0;
        check_eq("rst_mid_beats", read_beats - b0, 32'd2);
        b0 = read_beats;
        do_access(1'b1, 1'b0, 32'h80, 32'h0, stalls);
        check_eq("rd80_stalls", stalls, 32'd5);
        check_eq("rd80_beats", read_beats - b0, 32'd4);
        check_eq("rd80_data", dmemRData, 32'h1000_0020);
        do_access(1'b1, 1'b0, 32'h40, 32'h0, stalls);
        check_eq("rd40_post_rst_stalls", stalls, 32'd5);

        // Read and write together behave as a write.
        w0 = write_cnt;
        b0 = read_beats;
        do_access(1'b1, 1'b1, 32'h200, 32'h55AA_55AA, stalls);
        check_eq("rw_stalls", stalls, 32'd2);
        check_eq("rw_writes", write_cnt - w0, 32'd1);
        check_eq("rw_we", {31'h0, last_we}, 32'h1);
        check_eq("rw_addr", last_waddr, 32'h200);
        check_eq("rw_no_refill", read_beats - b0, 32'd0);

        // Access in the cycle right after RESUME.
        do_access(1'b1, 1'b0, 32'h44, 32'h0, stalls);
        check_eq("post_resume_stalls", stalls, 32'd0);
        check_eq("post_resume_data", dmemRData, 32'hDEAD_BEEF);
        idle_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
